// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters with a registered one-hot grant and index.
// Optional forced revocation of long holds is enabled by defining RR_ARBITER8_TIMEOUT_EN.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [7:0] i_req,
  output logic [7:0] o_grant,
  output logic [2:0] o_grant_idx,
  output logic       o_valid,
  output logic       o_timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, idx_n, sel, nxt;
  logic [7:0] grant_n, others;
  logic rel, force_rel;
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end
  function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] s);
    pick = s;
    for (int i = 7; i >= 0; i--) if (v[s + 3'(i)]) pick = s + 3'(i);
  endfunction
  assign others = i_req & ~o_grant;
  assign sel = pick(i_req, ptr);
  assign nxt = pick(others, o_grant_idx + 3'd1);
  assign rel = state == GRANT && !i_req[o_grant_idx];
  assign o_valid = state == GRANT;
`ifdef RR_ARBITER8_TIMEOUT_EN
  logic [7:0] cnt, cnt_n;
  logic top, hold;
  assign top = cnt == 8'(MAX_HOLD - 1);
  assign force_rel = state == GRANT && i_en && i_req[o_grant_idx] && top && |others;
  assign hold = state == GRANT && i_en && !rel && !force_rel;
  // Hold counter: restarts on every new grant, saturates at the revocation threshold.
  always_comb cnt_n = hold ? (top ? cnt : cnt + 8'd1) : 8'd0;
  // Counter and one-cycle timeout pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
      o_timeout <= 1'b0;
    end else begin
      cnt <= cnt_n;
      o_timeout <= force_rel;
    end
  end
`else
  assign force_rel = 1'b0;
  assign o_timeout = 1'b0;
`endif
  // Next state: grant from IDLE, drop on disable, re-arbitrate from g+1 on release or revocation.
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    grant_n = o_grant;
    idx_n = o_grant_idx;
    if (state == IDLE) begin
      if (i_en && |i_req) begin
        state_n = GRANT;
        grant_n = 8'd1 << sel;
        idx_n = sel;
      end
    end else if (!i_en) begin
      state_n = IDLE;
      grant_n = '0;
      idx_n = '0;
      ptr_n = rel ? o_grant_idx + 3'd1 : ptr;
    end else if (rel || force_rel) begin
      ptr_n = o_grant_idx + 3'd1;
      state_n = |others ? GRANT : IDLE;
      grant_n = |others ? 8'd1 << nxt : '0;
      idx_n = |others ? nxt : '0;
    end
  end
  // State, pointer and grant registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      ptr <= '0;
      o_grant <= '0;
      o_grant_idx <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      o_grant <= grant_n;
      o_grant_idx <= idx_n;
    end
  end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench for rr_arbiter8 against a behavioural round-robin model.
module tb_rr_arbiter8;
  localparam int MAXH = 4;
`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 0, rst_n = 1, en = 0;
  logic [7:0] req = 0;
  logic [7:0] grant;
  logic [2:0] idx;
  logic valid, tmo;
  rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req(req),
    .o_grant(grant), .o_grant_idx(idx), .o_valid(valid), .o_timeout(tmo)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [7:0] g; logic [2:0] i; logic v; logic t;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  int m_g = -1, m_ptr = 0, m_hold = 0;
  function automatic int first_from(input logic [7:0] v, input int s);
    for (int k = 0; k < 8; k++) if (v[(s + k) % 8]) return (s + k) % 8;
    return -1;
  endfunction
  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask
  // Reference model: whoever holds the grant keeps it until release, disable or timeout.
  always @(negedge rst_n) begin
    m_g = -1; m_ptr = 0; m_hold = 0;
    q.delete();
  end
  always @(posedge clk) begin
    bit f;
    logic [7:0] oth;
    f = 0;
    if (!rst_n) q.push_back('0);
    else begin
      if (m_g < 0) begin
        if (en && req != 0) begin m_g = first_from(req, m_ptr); m_hold = 0; end
      end else if (!en) begin
        if (!req[m_g]) m_ptr = (m_g + 1) % 8;
        m_g = -1; m_hold = 0;
      end else begin
        oth = req; oth[m_g] = 1'b0;
        f = TO && req[m_g] && m_hold == MAXH - 1 && oth != 0;
        if (!req[m_g] || f) begin
          m_ptr = (m_g + 1) % 8;
          m_g = first_from(oth, m_ptr);
          m_hold = 0;
        end else if (m_hold < MAXH - 1) m_hold++;
      end
      q.push_back({m_g < 0 ? 8'd0 : 8'(1 << m_g), m_g < 0 ? 3'd0 : 3'(m_g), 1'(m_g >= 0), f});
    end
  end
  // Monitor: compare every registered output against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("grant", grant, e.g);
      chk("idx", idx, e.i);
      chk("valid", valid, e.v);
      chk("timeout", tmo, e.t);
    end
  end
  task automatic step(input bit e, input logic [7:0] r);
    en = e; req = r;
    @(posedge clk); #1;
  endtask
  task automatic rst_pulse();
    rst_n = 0; #1;
    chk("rst_grant", grant, 0);
    chk("rst_idx", idx, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", tmo, 0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  initial begin
    logic [7:0] r;
    #2 rst_pulse();
    repeat (3) step(1, 8'hFF);
    rst_pulse();
    step(1, 8'hFF);
    chk("t1_idx", idx, 0);
    chk("t1_valid", valid, 1);
    step(1, 8'h04);
    chk("t2_grant", grant, 8'h04);
    chk("t2_idx", idx, 2);
    step(1, 8'h00);
    chk("t2_idle", valid, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 8'h81);
      step(1, 8'h81);
      step(1, 8'h81 & ~grant);
    end
    rst_pulse();
    step(1, 8'h0A);
    chk("t4_idx1", idx, 1);
    step(1, 8'h08);
    chk("t4_idx3", idx, 3);
    chk("t4_nogap", valid, 1);
    step(1, 8'h10);
    step(1, 8'h00);
    step(1, 8'h20);
    chk("t5_idx5", idx, 5);
    step(0, 8'h20);
    chk("t5_off", valid, 0);
    step(1, 8'hFF);
    chk("t5_ptr", idx, 5);
    rst_pulse();
    repeat (5) step(1, 8'h03);
    if (TO) begin
      chk("t6_revoke", idx, 1);
      chk("t6_pulse", tmo, 1);
    end
    step(1, 8'h03);
    chk("t6_pulse_end", tmo, 0);
    repeat (12) step(1, 8'h01);
    chk("t6_hold", idx, 0);
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 99) == 0) rst_pulse();
      r = 8'($urandom);
      if (valid && $urandom_range(0, 3) != 0) r[idx] = 1'b1;
      step($urandom_range(0, 9) != 0, r);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
